// File: rtl/multi_edge_pulse_pkg.sv
// Shared definitions for the multi-channel level-to-pulse converter:
// edge-select encodings, per-channel repeat FSM states and a sizing helper.
package multi_edge_pulse_pkg;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    typedef enum logic [1:0] {
        ST_LOW    = 2'b00,
        ST_HOLD   = 2'b01,
        ST_REPEAT = 2'b11
    } chan_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/multi_edge_pulse_chan.sv
// One input channel: synchroniser, debouncer, edge detector and auto-repeat FSM.
// o_pulse_next is the combinational event that o_pulse registers one cycle later.
module multi_edge_pulse_chan
    import multi_edge_pulse_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 3,
    parameter int HOLD_CYCLES     = 10,
    parameter int REPEAT_CYCLES   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_lvl,
    input  logic [1:0] i_mode,
    input  logic       i_repeat_en,
    output logic       o_pulse,
    output logic       o_pulse_next,
    output logic       o_level
);

    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMR_W = $clog2(max_int(HOLD_CYCLES, REPEAT_CYCLES));
    localparam logic [DEB_W-1:0] DEB_LAST      = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] HOLD_RELOAD   = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] REPEAT_RELOAD = TMR_W'(REPEAT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [DEB_W-1:0]       r_deb_cnt;
    logic                   r_filt;
    logic                   r_filt_d;
    logic                   r_pulse;
    chan_state_t            r_state;
    chan_state_t            w_state_next;
    logic [TMR_W-1:0]       r_timer;
    logic [TMR_W-1:0]       w_timer_next;
    logic                   w_sync;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_rep;
    logic                   w_rise_en;
    logic                   w_fall_en;

    assign w_sync = r_sync[SYNC_STAGES-1];
    assign w_rise = r_filt & ~r_filt_d;
    assign w_fall = ~r_filt & r_filt_d;

    // A level change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync    <= '0;
            r_deb_cnt <= '0;
            r_filt    <= 1'b0;
            r_filt_d  <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], i_lvl};
            r_filt_d <= r_filt;
            if (w_sync == r_filt) begin
                r_deb_cnt <= '0;
            end else if (r_deb_cnt == DEB_LAST) begin
                r_filt    <= w_sync;
                r_deb_cnt <= '0;
            end else begin
                r_deb_cnt <= r_deb_cnt + DEB_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_LOW;
            r_timer <= '0;
        end else begin
            r_state <= w_state_next;
            r_timer <= w_timer_next;
        end
    end

    // A release beats a simultaneous timer expiry; disabling repeat parks the timer at reload.
    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer;
        w_rep        = 1'b0;
        case (r_state)
            ST_LOW: begin
                if (w_rise) begin
                    w_state_next = ST_HOLD;
                    w_timer_next = HOLD_RELOAD;
                end
            end
            ST_HOLD, ST_REPEAT: begin
                if (w_fall) begin
                    w_state_next = ST_LOW;
                    w_timer_next = '0;
                end else if (!i_repeat_en) begin
                    w_state_next = ST_HOLD;
                    w_timer_next = HOLD_RELOAD;
                end else if (r_timer == '0) begin
                    w_rep        = 1'b1;
                    w_state_next = ST_REPEAT;
                    w_timer_next = REPEAT_RELOAD;
                end else begin
                    w_timer_next = r_timer - TMR_W'(1);
                end
            end
            default: begin
                w_state_next = ST_LOW;
                w_timer_next = '0;
            end
        endcase
    end

    assign w_rise_en    = (i_mode == MODE_RISE) || (i_mode == MODE_BOTH);
    assign w_fall_en    = (i_mode == MODE_FALL) || (i_mode == MODE_BOTH);
    assign o_pulse_next = (i_mode != MODE_OFF) &&
                          ((w_rise & w_rise_en) | (w_fall & w_fall_en) | (w_rep & w_rise_en));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= o_pulse_next;
        end
    end

    assign o_pulse = r_pulse;
    assign o_level = r_filt;

endmodule

// File: rtl/multi_edge_pulse.sv
// Multi-channel debounced level-to-pulse converter with optional auto-repeat.
// Channels are independent; any_pulse is registered alongside the pulse vector.
module multi_edge_pulse
    import multi_edge_pulse_pkg::*;
#(
    parameter int CHANNELS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 3,
    parameter int HOLD_CYCLES     = 10,
    parameter int REPEAT_CYCLES   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CHANNELS-1:0]   lvl,
    input  logic [2*CHANNELS-1:0] mode,
    input  logic [CHANNELS-1:0]   repeat_en,
    output logic [CHANNELS-1:0]   pulse,
    output logic [CHANNELS-1:0]   level,
    output logic                  any_pulse
);

    logic [CHANNELS-1:0] w_pulse_next;
    logic                r_any_pulse;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            multi_edge_pulse_chan #(
                .SYNC_STAGES    (SYNC_STAGES),
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .HOLD_CYCLES    (HOLD_CYCLES),
                .REPEAT_CYCLES  (REPEAT_CYCLES)
            ) u_chan (
                .clk         (clk),
                .reset       (reset),
                .i_lvl       (lvl[gi]),
                .i_mode      (mode[2*gi+1 -: 2]),
                .i_repeat_en (repeat_en[gi]),
                .o_pulse     (pulse[gi]),
                .o_pulse_next(w_pulse_next[gi]),
                .o_level     (level[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_any_pulse <= 1'b0;
        end else begin
            r_any_pulse <= |w_pulse_next;
        end
    end

    assign any_pulse = r_any_pulse;

endmodule

// File: tb/tb_multi_edge_pulse.sv
// Scoreboard bench: expected pulses are queued by cycle when stimulus is driven and
// compared against pulse/any_pulse on every falling edge.
module tb_multi_edge_pulse;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] lvl;
    logic [7:0] mode;
    logic [3:0] repeat_en;
    logic [3:0] pulse;
    logic [3:0] level;
    logic       any_pulse;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit mon_en  = 1'b0;

    typedef struct {
        int cyc;
        int ch;
    } exp_t;
    exp_t sb_q[$];

    multi_edge_pulse #(
        .CHANNELS(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(3),
        .HOLD_CYCLES(10), .REPEAT_CYCLES(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .lvl      (lvl),
        .mode     (mode),
        .repeat_en(repeat_en),
        .pulse    (pulse),
        .level    (level),
        .any_pulse(any_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic push_exp(input int c, input int ch);
        exp_t e;
        e.cyc = c;
        e.ch  = ch;
        sb_q.push_back(e);
    endtask

    task automatic run_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Pulses are "at edge n" when visible on the falling edge with cyc == n.
    always @(negedge clk) begin : mon
        logic [3:0] v;
        if (mon_en) begin
            v = '0;
            for (int i = sb_q.size() - 1; i >= 0; i--) begin
                if (sb_q[i].cyc == cyc) begin
                    v[sb_q[i].ch] = 1'b1;
                    sb_q.delete(i);
                end
            end
            if (v != 4'h0 || pulse != 4'h0)
                $display("[TB] cyc %0d pulse=%b expected=%b any=%b", cyc, pulse, v, any_pulse);
            check_eq("pulse", 32'(pulse), 32'(v));
            check_eq("any_pulse", 32'(any_pulse), 32'(|v));
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int r;
        reset     = 1'b1;
        lvl       = 4'hF;
        mode      = 8'h55;
        repeat_en = 4'h0;

        // 1: reset with inputs high, then release -> all channels pulse together
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        check_eq("rst_level", 32'(level), 32'h0);
        check_eq("rst_pulse", 32'(pulse), 32'h0);
        reset = 1'b0;
        t = cyc + 1;
        for (int ch = 0; ch < 4; ch++) push_exp(t + 5, ch);
        run_until(t + 3);
        check_eq("t1_level_pre", 32'(level), 32'h0);
        run_until(t + 4);
        check_eq("t1_level_hi", 32'(level), 32'hF);
        run_until(t + 8);
        lvl = 4'h0;
        run_until(t + 20);
        check_eq("t1_level_lo", 32'(level), 32'h0);

        // 2: two-cycle glitch on ch0 is rejected
        lvl[0] = 1'b1;
        t = cyc + 1;
        run_until(t + 1);
        lvl[0] = 1'b0;
        for (int k = 2; k < 12; k++) begin
            run_until(t + k);
            check_eq("t2_level0", 32'(level[0]), 32'h0);
        end

        // 3: ch1 both edges, no repeat
        mode[3:2] = 2'b11;
        @(negedge clk);
        lvl[1] = 1'b1;
        t = cyc + 1;
        push_exp(t + 5, 1);
        push_exp(t + 25, 1);
        for (int k = 0; k < 31; k++) begin
            run_until(t + k);
            check_eq("t3_level1", 32'(level[1]), 32'((k >= 4) && (k < 24)));
            if (k == 19) lvl[1] = 1'b0;
        end

        // 4: ch2 auto-repeat while held for 30 cycles
        repeat_en = 4'b0100;
        @(negedge clk);
        lvl[2] = 1'b1;
        t = cyc + 1;
        push_exp(t + 5, 2);
        push_exp(t + 15, 2);
        push_exp(t + 19, 2);
        push_exp(t + 23, 2);
        push_exp(t + 27, 2);
        push_exp(t + 31, 2);
        for (int k = 0; k < 41; k++) begin
            run_until(t + k);
            if (k == 29) lvl[2] = 1'b0;
        end
        check_eq("t4_level2", 32'(level[2]), 32'h0);
        repeat_en = 4'h0;

        // 5: ch3 fall-only (repeats suppressed), then mode off mid-hold
        mode[7:6]    = 2'b10;
        repeat_en[3] = 1'b1;
        @(negedge clk);
        lvl[3] = 1'b1;
        t = cyc + 1;
        push_exp(t + 17, 3);
        for (int k = 0; k < 26; k++) begin
            run_until(t + k);
            if (k == 4) check_eq("t5_level3", 32'(level[3]), 32'h1);
            if (k == 11) lvl[3] = 1'b0;
        end
        lvl[3] = 1'b1;
        t = cyc + 1;
        for (int k = 0; k < 26; k++) begin
            run_until(t + k);
            if (k == 8) mode[7:6] = 2'b00;
            if (k == 11) lvl[3] = 1'b0;
        end
        check_eq("t5_level3_off", 32'(level[3]), 32'h0);
        repeat_en = 4'h0;
        mode      = 8'h55;

        // 6: reset while ch2 is repeating, lvl stays high afterwards
        repeat_en[2] = 1'b1;
        @(negedge clk);
        lvl[2] = 1'b1;
        t = cyc + 1;
        push_exp(t + 5, 2);
        push_exp(t + 15, 2);
        push_exp(t + 19, 2);
        run_until(t + 20);
        reset = 1'b1;
        run_until(t + 21);
        check_eq("t6_rst_level", 32'(level), 32'h0);
        check_eq("t6_rst_pulse", 32'(pulse), 32'h0);
        run_until(t + 23);
        reset = 1'b0;
        r = t + 24;
        push_exp(r + 5, 2);
        push_exp(r + 15, 2);
        push_exp(r + 19, 2);
        push_exp(r + 23, 2);
        run_until(r + 3);
        check_eq("t6_level_pre", 32'(level[2]), 32'h0);
        run_until(r + 4);
        check_eq("t6_level_hi", 32'(level[2]), 32'h1);
        run_until(r + 20);
        lvl[2] = 1'b0;
        run_until(r + 35);
        check_eq("t6_level_lo", 32'(level[2]), 32'h0);

        check_eq("sb_empty", 32'(sb_q.size()), 32'h0);
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
